rose_pulse_driver: RTL and testbench
====================================

// Module: rose_pulse_driver
// PURPOSE
//   Stimulus-side counterpart of the a |-> $rose(b) check. It accepts pulse requests over a
//   valid/ready handshake and drives the a/b pair so that the property always holds.
//   a_out is high only on the cycle where b_out rises. b_out then stays high for the
//   requested length. It then stays low for at least MIN_LOW cycles before the next rise.
//   The block sits between a test sequencer and the DUT inputs or assertion monitor.
// PARAMETERS
//   LEN_W    4    width of req_len (high-time request)
//   MIN_LOW  1    minimum b_out low cycles between pulses; legal range >= 1
//   CNT_W    16   width of statistics counters (used only with ROSE_DRV_STATS_EN)
// PORTS
//   clk          in   1      single clock, all logic on posedge
//   rst          in   1      asynchronous, active-high reset
//   req_valid    in   1      pulse request valid
//   req_ready    out  1      block can accept a request this cycle
//   req_len      in   LEN_W  b_out high cycles; 0 is treated as 1
//   abort        in   1      synchronous: terminate the active pulse
//   a_out        out  1      qualifier; high exactly on each b_out rise cycle
//   b_out        out  1      pulse output
//   busy         out  1      high while in HIGH or LOW state
//   evt_count    out  CNT_W  accepted pulses (ROSE_DRV_STATS_EN only)
//   abort_count  out  CNT_W  aborted pulses (ROSE_DRV_STATS_EN only)
// BEHAVIOUR
// - Clocking and reset
//   - One clock: clk. Reset is asynchronous and active-high: rst.
//   - Reset forces state=IDLE and a_out=b_out=busy=0. Stats counters reset to 0.
//   - A reset asserted mid-pulse drops b_out immediately, without waiting for a clock edge.
//   - After reset release, the low-time requirement counts as already met: req_ready may be
//     high in the first cycle.
// - Outputs
//   - a_out, b_out and busy are registered.
//   - req_ready is combinational from state and abort only.
// - States: IDLE, HIGH, LOW
//   - IDLE: b_out=0, a_out=0. req_ready = !abort.
//   - Accept occurs on a posedge with req_valid && req_ready. The block latches
//     L = (req_len==0) ? 1 : req_len.
//   - The next cycle goes to HIGH with a_out=1 and b_out=1. Latency from accept is 1 cycle.
//   - HIGH: b_out=1 for exactly L cycles; a_out=1 only in the first of them.
//   - After the last HIGH cycle, go to LOW with b_out=0.
//   - LOW: b_out=0. req_ready rises in the MIN_LOW-th low cycle.
//   - An accept in that cycle produces a rise in the following cycle. Back-to-back pulses
//     therefore have exactly MIN_LOW low cycles between them.
//   - With no accept, the block returns to IDLE. busy=0 in IDLE.
//   - HIGH and LOW deassert req_ready, except in the final LOW cycle as above.
// - abort
//   - abort high in HIGH: b_out=0 from the next cycle, state goes to LOW, and the low-time
//     count restarts.
//   - abort high in LOW restarts the low-time count. abort high in IDLE only blocks req_ready.
//   - abort takes priority over accept in the same cycle, because req_ready=0 while abort=1.
// - Invariants
//   - a_out==1 implies b_out==1 this cycle and b_out==0 the previous cycle.
//   - a_out is never high on consecutive cycles.
//   - b_out never rises without a_out.
//   - req_len is sampled only at accept; later changes have no effect.
// CONFIGURATION
//   ROSE_DRV_STATS_EN defined:
//   - evt_count increments on each accept.
//   - abort_count increments on each abort taken in HIGH.
//   - Both counters saturate at all-ones and are cleared by rst.
//   ROSE_DRV_STATS_EN undefined:
//   - Both counter ports and their logic are absent; all other behaviour is identical.
// TESTING
//   1. rst pulse, then req_valid=1 with req_len=3 held at cycle 2 -> a_out=1 at cycle 3 only;
//      b_out=1 at cycles 3-5 and 0 at cycle 6; req_ready=1 at cycle 6 (MIN_LOW=1).
//   2. Continuous req_valid, req_len=1, MIN_LOW=1 -> b_out and a_out toggle 1,0,1,0.
//      No a_out without a $rose(b_out).
//   3. MIN_LOW=3, two back-to-back len=2 requests -> exactly 3 low cycles between pulses;
//      req_ready is high only in the third low cycle.
//   4. req_len=0 -> treated as a 1-cycle pulse. req_len=15 -> 15 high cycles.
//      Changing req_len mid-pulse has no effect.
//   5. abort in the 2nd HIGH cycle of a len=8 pulse -> b_out=0 the next cycle;
//      abort_count=1 and evt_count=1 (STATS).
//      abort with req_valid in IDLE -> no accept.
//   6. rst asserted asynchronously mid-HIGH -> b_out=0 before the next posedge.
//      After release, a new request pulses normally; counters read 0.

Source files
------------

// File: rtl/rose_pulse_driver.sv
// Drives an a/b stimulus pair so that a |-> $rose(b) always holds, with handshake-fed pulse lengths.
// Optional statistics counters are compiled in when ROSE_DRV_STATS_EN is defined.
module rose_pulse_driver #(
    parameter int LEN_W   = 4,
    parameter int MIN_LOW = 1
`ifdef ROSE_DRV_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_len,
    input  logic             abort,
    output logic             a_out,
    output logic             b_out,
    output logic             busy
`ifdef ROSE_DRV_STATS_EN
    ,
    output logic [CNT_W-1:0] evt_count,
    output logic [CNT_W-1:0] abort_count
`endif
);

    localparam int LOW_W = (MIN_LOW > 1) ? $clog2(MIN_LOW) : 1;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  hi_cnt, hi_cnt_nxt;
    logic [LOW_W-1:0]  low_cnt, low_cnt_nxt;
    logic              a_nxt, b_nxt, busy_nxt;
    logic              accept, hi_last, low_last;
    logic [LEN_W-1:0]  len_m1;

    // hi_cnt holds remaining high cycles minus one; low_cnt is the current low cycle index.
    assign hi_last  = (hi_cnt == '0);
    assign low_last = (low_cnt == LOW_W'(MIN_LOW - 1));
    assign len_m1   = (req_len == '0) ? '0 : req_len - LEN_W'(1);
    assign accept   = req_valid && req_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hi_cnt  <= '0;
            low_cnt <= '0;
            a_out   <= 1'b0;
            b_out   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            hi_cnt  <= hi_cnt_nxt;
            low_cnt <= low_cnt_nxt;
            a_out   <= a_nxt;
            b_out   <= b_nxt;
            busy    <= busy_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt   = state;
        hi_cnt_nxt  = hi_cnt;
        low_cnt_nxt = low_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt  = HIGH;
                    hi_cnt_nxt = len_m1;
                end
            end
            HIGH: begin
                if (abort || hi_last) begin
                    state_nxt   = LOW;
                    low_cnt_nxt = '0;
                end else begin
                    hi_cnt_nxt = hi_cnt - LEN_W'(1);
                end
            end
            LOW: begin
                if (abort) begin
                    low_cnt_nxt = '0;
                end else if (accept) begin
                    state_nxt  = HIGH;
                    hi_cnt_nxt = len_m1;
                end else if (low_last) begin
                    state_nxt = IDLE;
                end else begin
                    low_cnt_nxt = low_cnt + LOW_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // a_out marks entry into HIGH; since LOW always separates pulses it cannot repeat.
    always_comb begin
        req_ready = 1'b0;
        case (state)
            IDLE:    req_ready = !abort;
            LOW:     req_ready = low_last && !abort;
            default: req_ready = 1'b0;
        endcase
        b_nxt    = (state_nxt == HIGH);
        a_nxt    = (state_nxt == HIGH) && (state != HIGH);
        busy_nxt = (state_nxt != IDLE);
    end

`ifdef ROSE_DRV_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_count   <= '0;
            abort_count <= '0;
        end else begin
            if (accept && (evt_count != '1))
                evt_count <= evt_count + CNT_W'(1);
            if ((state == HIGH) && abort && (abort_count != '1))
                abort_count <= abort_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rose_pulse_driver.sv
// Self-checking bench: two instances (MIN_LOW=1 and MIN_LOW=3) against a cycle-history reference model.
module tb_rose_pulse_driver;

    localparam int BIG = 1000;
    localparam int ML0 = 1;
    localparam int ML1 = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_len = '0;
    logic       abort = 1'b0;
    logic [1:0] rdy, a, b, bsy;
`ifdef ROSE_DRV_STATS_EN
    logic [15:0] evt0, abt0, evt1, abt1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rose_pulse_driver #(.LEN_W(4), .MIN_LOW(ML0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_len(req_len), .abort(abort), .a_out(a[0]), .b_out(b[0]), .busy(bsy[0])
`ifdef ROSE_DRV_STATS_EN
        , .evt_count(evt0), .abort_count(abt0)
`endif
    );

    rose_pulse_driver #(.LEN_W(4), .MIN_LOW(ML1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_len(req_len), .abort(abort), .a_out(a[1]), .b_out(b[1]), .busy(bsy[1])
`ifdef ROSE_DRV_STATS_EN
        , .evt_count(evt1), .abort_count(abt1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: high cycles left, consecutive low cycles counted so far (BIG = long idle).
    int hi_left[2];
    int low_run[2];
    bit first[2];
    int ev_cnt[2];
    int ab_cnt[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int  ml;
            bit  e_rdy, acc;
            ml = (i == 0) ? ML0 : ML1;
            if (rst) begin
                hi_left[i] = 0; low_run[i] = BIG; first[i] = 0;
                ev_cnt[i] = 0; ab_cnt[i] = 0;
            end else begin
                e_rdy = !abort && hi_left[i] == 0 && low_run[i] >= ml;
                check($sformatf("ready%0d", i), rdy[i], e_rdy);
                check($sformatf("b%0d", i), b[i], hi_left[i] > 0);
                check($sformatf("a%0d", i), a[i], first[i]);
                check($sformatf("busy%0d", i), bsy[i], hi_left[i] > 0 || low_run[i] <= ml);
`ifdef ROSE_DRV_STATS_EN
                check($sformatf("evt%0d", i), (i == 0) ? evt0 : evt1, ev_cnt[i]);
                check($sformatf("abt%0d", i), (i == 0) ? abt0 : abt1, ab_cnt[i]);
`endif
                acc = req_valid && e_rdy;
                if (acc) begin
                    hi_left[i] = (req_len == 0) ? 1 : int'(req_len);
                    first[i] = 1;
                    ev_cnt[i]++;
                end else if (hi_left[i] > 0) begin
                    first[i] = 0;
                    if (abort) begin
                        hi_left[i] = 0; low_run[i] = 1; ab_cnt[i]++;
                    end else begin
                        hi_left[i]--;
                        if (hi_left[i] == 0) low_run[i] = 1;
                    end
                end else begin
                    first[i] = 0;
                    if (abort && low_run[i] <= ml) low_run[i] = 1;
                    else if (low_run[i] < BIG) low_run[i]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; req_valid = 1'b0; abort = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [7:0] va0, vb0, vb1, vr1;
    logic [3:0] sa, sb;

    initial begin
        do_reset();
        check("reset_b", b, 2'b00);
        check("reset_a", a, 2'b00);
        check("reset_busy", bsy, 2'b00);
        check("reset_ready", rdy, 2'b11);

        // Single len=3 pulse on MIN_LOW=1 instance.
        req_valid = 1'b1; req_len = 4'd3;
        step();
        req_valid = 1'b0;
        sa = '0; sb = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sa = {sa[2:0], a[0]};
            sb = {sb[2:0], b[0]};
        end
        check("t1_a", sa, 4'b1000);
        check("t1_b", sb, 4'b1110);
        check("t1_ready", rdy[0], 1'b1);

        // Continuous len=2 requests on both instances.
        do_reset();
        req_valid = 1'b1; req_len = 4'd2;
        va0 = '0; vb0 = '0; vb1 = '0; vr1 = '0;
        step();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            va0 = {va0[6:0], a[0]};
            vb0 = {vb0[6:0], b[0]};
            vb1 = {vb1[6:0], b[1]};
            vr1 = {vr1[6:0], rdy[1]};
        end
        check("b2b_a0", va0, 8'b10010010);
        check("b2b_b0", vb0, 8'b11011011);
        check("b2b_b1", vb1, 8'b11000110);
        check("b2b_ready1", vr1, 8'b00001000);
        step();
        req_valid = 1'b0;

        // Abort in the second HIGH cycle of a len=8 pulse.
        do_reset();
        req_valid = 1'b1; req_len = 4'd8;
        step();
        req_valid = 1'b0;
        step();
        abort = 1'b1;
        @(negedge clk);
        check("abort_b_still_high", b[0], 1'b1);
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abort_b_low", b[0], 1'b0);
`ifdef ROSE_DRV_STATS_EN
        check("abort_evt", evt0, 16'd1);
        check("abort_cnt", abt0, 16'd1);
`endif
        for (int k = 0; k < 6; k++) step();
        abort = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        check("idle_abort_ready", rdy, 2'b00);
        step();
        abort = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("idle_abort_b", b, 2'b00);
        check("idle_abort_busy", bsy, 2'b00);

        // Asynchronous reset mid-HIGH, then a len=0 request.
        req_valid = 1'b1; req_len = 4'd15;
        step();
        req_valid = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("async_rst_b", b, 2'b00);
        check("async_rst_busy", bsy, 2'b00);
        step();
        rst = 1'b0;
        req_valid = 1'b1; req_len = 4'd0;
`ifdef ROSE_DRV_STATS_EN
        @(negedge clk);
        check("rst_evt", evt0, 16'd0);
        check("rst_abt", abt0, 16'd0);
`endif
        step();
        req_valid = 1'b0;
        @(negedge clk);
        check("len0_first", {a[0], b[0]}, 2'b11);
        step();
        @(negedge clk);
        check("len0_second", {a[0], b[0]}, 2'b00);

        // Randomized traffic, including occasional resets and mid-pulse length changes.
        for (int k = 0; k < 3000; k++) begin
            step();
            rst       = ($urandom_range(0, 299) == 0);
            req_valid = ($urandom_range(0, 99) < 60);
            req_len   = 4'($urandom);
            abort     = ($urandom_range(0, 99) < 4);
        end
        step();
        rst = 1'b0; req_valid = 1'b0; abort = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
